// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Handshake: start_i is a request that is taken only when busy_o is low and flush_i is low; done_o is a one-cycle completion pulse.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  busy_o, stall_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output busy_o, stall_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with early completion for divide special cases and optional one-cycle multiply.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  muldiv_if.slave    bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]      op_q;
  logic            neg_q;
  logic            rem_neg_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   cnt_q;

  logic              accept;
  logic              is_mul_in;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              div_ovf;
  logic              early;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   early_result;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   step_acc;
  logic [XLEN-1:0]   step_lo;
  logic [XLEN-1:0]   final_result;

  // Sign-correct a magnitude product and pick the half the opcode asks for.
  function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] mag,
                                                 input logic neg,
                                                 input logic [1:0] op);
    logic [2*XLEN-1:0] p;
    p = neg ? -mag : mag;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    is_mul_in = ~bus.op_i[2];
    a_signed  = bus.op_i[2] ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
    b_signed  = bus.op_i[2] ? ~bus.op_i[0] : ~bus.op_i[1];
    a_neg     = a_signed & bus.rs1_i[XLEN-1];
    b_neg     = b_signed & bus.rs2_i[XLEN-1];
    a_mag     = a_neg ? -bus.rs1_i : bus.rs1_i;
    b_mag     = b_neg ? -bus.rs2_i : bus.rs2_i;
    div_zero  = bus.op_i[2] & (bus.rs2_i == '0);
    div_ovf   = bus.op_i[2] & ~bus.op_i[0] & (bus.rs1_i == MIN) & (bus.rs2_i == '1);
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    early     = div_zero | div_ovf | (FAST_MUL & is_mul_in);
    early_result = '0;
    if (div_zero)     early_result = bus.op_i[1] ? bus.rs1_i : '1;
    else if (div_ovf) early_result = bus.op_i[1] ? '0 : MIN;
    else              early_result = mul_select(fast_prod, a_neg ^ b_neg, bus.op_i[1:0]);
  end

  // {acc_q, lo_q} is the running product for multiply, {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    step_acc  = acc_q;
    step_lo   = lo_q;
    if (!op_q[2]) begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_acc = div_diff[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_acc = div_shift[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], 1'b0};
    end
    final_result = '0;
    if (!op_q[2])     final_result = mul_select({step_acc, step_lo}, neg_q, op_q[1:0]);
    else if (op_q[1]) final_result = rem_neg_q ? -step_acc : step_acc;
    else              final_result = neg_q ? -step_lo : step_lo;
  end

  always_comb begin
    accept  = bus.start_i & ~bus.flush_i & (state_q != CALC);
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: state_d = accept ? (early ? DONE : CALC) : IDLE;
        CALC:       if (cnt_q == '0) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_q      <= bus.op_i;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      acc_q     <= '0;
      lo_q      <= a_mag;
      b_q       <= b_mag;
      rd_q      <= bus.rd_i;
      cnt_q     <= CW'(XLEN - 1);
      if (early) result_q <= early_result;
    end else if ((state_q == CALC) && !bus.flush_i) begin
      acc_q <= step_acc;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) result_q <= final_result;
    end
  end

  assign bus.busy_o   = (state_q == CALC);
  assign bus.stall_o  = (state_q == CALC) | (bus.start_i & ~bus.flush_i & (state_q != CALC));
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an iterative instance and a FAST_MUL instance share clock and reset.
module tb_muldiv_unit;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 100;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  muldiv_if #(.XLEN(XLEN)) bus0 ();
  muldiv_if #(.XLEN(XLEN)) bus1 ();

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
  );

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op on the iterative unit, then wait for done and score it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int c;
    int busy_cnt;
    @(negedge clk);
    bus0.start_i = 1'b1;
    bus0.op_i    = op;
    bus0.rs1_i   = a;
    bus0.rs2_i   = b;
    bus0.rd_i    = rd;
    exp_q.push_back(exp);
    #1 check({tag, "_stall"}, 32'(bus0.stall_o), 32'd1);
    @(negedge clk);
    bus0.start_i = 1'b0;
    bus0.rs1_i   = $urandom;
    bus0.rs2_i   = $urandom;
    bus0.rd_i    = 5'($urandom);
    c        = 1;
    busy_cnt = 0;
    while (!bus0.done_o && c < TIMEOUT) begin
      if (bus0.busy_o) busy_cnt++;
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, 32'(bus0.done_o), 32'd1);
    check({tag, "_lat"}, c, lat);
    check({tag, "_result"}, bus0.result_o, exp_q.pop_front());
    check({tag, "_rd"}, 32'(bus0.rd_o), 32'(rd));
    check({tag, "_busy"}, busy_cnt, lat - 1);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus0.done_o), 32'd0);
  endtask

  task automatic idle_inputs();
    bus0.start_i = 1'b0; bus0.op_i = '0; bus0.rs1_i = '0; bus0.rs2_i = '0;
    bus0.rd_i = '0; bus0.flush_i = 1'b0;
    bus1.start_i = 1'b0; bus1.op_i = '0; bus1.rs1_i = '0; bus1.rs2_i = '0;
    bus1.rd_i = '0; bus1.flush_i = 1'b0;
  endtask

  initial begin
    int  c;
    bit  saw_done;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(bus0.busy_o), 32'd0);
    check("rst_done", 32'(bus0.done_o), 32'd0);
    check("rst_result", bus0.result_o, 32'd0);
    check("rst_rd", 32'(bus0.rd_o), 32'd0);
    check("rst_stall", 32'(bus0.stall_o), 32'd0);
    check("rst_state", 32'(dbg0), 32'(ST_IDLE));
    check("rst_fast_result", bus1.result_o, 32'd0);

    run_op("mul_neg", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run_op("remu", OP_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 33);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
    run_op("rem_zero", OP_REM, 32'd5, 32'd0, 5'd16, 32'd5, 1);

    // Flush a divide at iteration 10; result stays at the previous value 5.
    @(negedge clk);
    bus0.start_i = 1'b1; bus0.op_i = OP_DIV; bus0.rs1_i = 32'hFFFF_FFF9;
    bus0.rs2_i = 32'd2; bus0.rd_i = 5'd17;
    @(negedge clk);
    bus0.start_i = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (bus0.done_o) saw_done = 1'b1;
      @(negedge clk);
    end
    check("flush_pre_busy", 32'(bus0.busy_o), 32'd1);
    bus0.flush_i = 1'b1;
    @(negedge clk);
    bus0.flush_i = 1'b0;
    check("flush_state", 32'(dbg0), 32'(ST_IDLE));
    check("flush_busy", 32'(bus0.busy_o), 32'd0);
    check("flush_result", bus0.result_o, 32'd5);
    for (int i = 0; i < 40; i++) begin
      if (bus0.done_o) saw_done = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", 32'(saw_done), 32'd0);
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 5'd18, 32'd12, 33);

    // Start and flush together: the start is dropped.
    @(negedge clk);
    bus0.start_i = 1'b1; bus0.flush_i = 1'b1; bus0.op_i = OP_DIVU;
    bus0.rs1_i = 32'd9; bus0.rs2_i = 32'd0; bus0.rd_i = 5'd19;
    #1 check("flush_start_stall", 32'(bus0.stall_o), 32'd0);
    @(negedge clk);
    bus0.start_i = 1'b0; bus0.flush_i = 1'b0;
    check("flush_start_state", 32'(dbg0), 32'(ST_IDLE));
    check("flush_start_done", 32'(bus0.done_o), 32'd0);
    check("flush_start_result", bus0.result_o, 32'd12);

    // Reset in the middle of CALC.
    @(negedge clk);
    bus0.start_i = 1'b1; bus0.op_i = OP_DIVU; bus0.rs1_i = 32'd100;
    bus0.rs2_i = 32'd7; bus0.rd_i = 5'd20;
    @(negedge clk);
    bus0.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus0.busy_o), 32'd0);
    check("rst_mid_done", 32'(bus0.done_o), 32'd0);
    check("rst_mid_result", bus0.result_o, 32'd0);
    check("rst_mid_rd", 32'(bus0.rd_o), 32'd0);
    check("rst_mid_state", 32'(dbg0), 32'(ST_IDLE));

    // One-cycle multiply, then a divide accepted in the DONE cycle.
    @(negedge clk);
    bus1.start_i = 1'b1; bus1.op_i = OP_MUL; bus1.rs1_i = 32'd6;
    bus1.rs2_i = 32'd7; bus1.rd_i = 5'd2;
    @(negedge clk);
    check("fast_done", 32'(bus1.done_o), 32'd1);
    check("fast_busy", 32'(bus1.busy_o), 32'd0);
    check("fast_result", bus1.result_o, 32'd42);
    check("fast_rd", 32'(bus1.rd_o), 32'd2);
    bus1.start_i = 1'b1; bus1.op_i = OP_DIVU; bus1.rs1_i = 32'd100;
    bus1.rs2_i = 32'd7; bus1.rd_i = 5'd3;
    #1 check("b2b_stall", 32'(bus1.stall_o), 32'd1);
    @(negedge clk);
    bus1.start_i = 1'b0;
    check("b2b_state", 32'(dbg1), 32'(ST_CALC));
    c = 1;
    while (!bus1.done_o && c < TIMEOUT) begin
      @(negedge clk);
      c++;
    end
    check("b2b_done", 32'(bus1.done_o), 32'd1);
    check("b2b_lat", c, 33);
    check("b2b_result", bus1.result_o, 32'd14);
    check("b2b_rd", 32'(bus1.rd_o), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
